trap_seq: RTL and testbench
===========================

# trap_seq

Trap sequencer downstream of the SCD flag logic. It samples the SCD arithmetic and pushdown trap requests (TRAP_REQ1/TRAP_REQ2) at each instruction boundary (NICOND). It arbitrates them against pending priority interrupts, then runs a handshaked trap cycle with the microcode: it presents the EPT/UPT trap offset, acknowledges the requests back to SCD, and watches for a hung trap cycle. It also keeps a saturating count of traps taken for diagnostics.

## Interface
- TIMEOUT, 255: maximum cycles spent in CYCLE before the sequencer declares a hang (1..255).
- CNT_W, 16: width of the traps-taken counter.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- TRAP_REQ1  in  1  arithmetic overflow trap request from SCD.
- TRAP_REQ2  in  1  pushdown overflow trap request from SCD.
- USER  in  1  user mode from SCD; selects UPT vs EPT.
- NICOND  in  1  one-cycle instruction-boundary strobe from microcode.
- PI_REQ  in  1  priority interrupt pending; outranks traps.
- TRAP_EN  in  1  trapping enabled (APR).
- TRAP_DONE  in  1  microcode has fetched/executed the trap instruction.
- HANG_CLR  in  1  clears TRAP_HANG.
- TRAP_PENDING  out  1  combinational: TRAP_REQ1|TRAP_REQ2.
- TRAP_CYC  out  1  trap cycle in progress.
- TRAP_ACK  out  1  one-cycle pulse telling SCD to clear TRAP_REQ1/2.
- TRAP_ADDR  out  9  trap offset, octal 420+code, valid while TRAP_CYC.
- TRAP_UPT  out  1  1 = offset is relative to UPT (user), 0 = EPT.
- TRAP_HANG  out  1  sticky timeout error.
- TRAP_COUNT  out  CNT_W  saturating count of trap cycles started.

## Operation
- code[1:0] = {TRAP_REQ2, TRAP_REQ1}; 1 = overflow, 2 = pushdown, 3 = both.
- States: IDLE, CYCLE, DRAIN.
- IDLE -> CYCLE when NICOND & TRAP_EN & ~PI_REQ & code!=0.
  - On this transition: latch code and USER, load the timeout counter with 0, and increment TRAP_COUNT (saturating at all-ones).
  - Then pulse TRAP_ACK.
- IDLE with NICOND & PI_REQ: the trap is deferred. No state change; requests remain pending in SCD.
- IDLE with NICOND & ~TRAP_EN: no trap. Requests are left untouched.
- CYCLE: TRAP_CYC=1; TRAP_ADDR = 9'o420 + latched code; TRAP_UPT = latched USER.
  - The timeout counter increments each cycle.
- CYCLE -> DRAIN on TRAP_DONE.
- CYCLE -> DRAIN with TRAP_HANG set when the counter equals TIMEOUT-1 and TRAP_DONE=0.
- TRAP_DONE in the same cycle as expiry: done wins, no hang.
- DRAIN -> IDLE unconditionally, one cycle. TRAP_CYC=0 in DRAIN. NICOND in DRAIN is ignored.
  - DRAIN guarantees SCD's cleared requests are seen before the next sample.
- NICOND while in CYCLE: ignored.
- TRAP_REQ changes while in CYCLE: no effect on the latched code. New requests are taken at a later boundary.
- TRAP_HANG is sticky. It is cleared by HANG_CLR (when no new hang is set the same cycle; set wins) or by reset.
- TRAP_ADDR and TRAP_UPT read 0 outside CYCLE.

## Timing
- Reset (rst_n=0 at an edge) values:
  - state IDLE
  - TRAP_CYC=0, TRAP_ACK=0
  - TRAP_ADDR=0, TRAP_UPT=0
  - TRAP_HANG=0, TRAP_COUNT=0
  - timeout counter 0, latched code 0
- Reset mid-cycle aborts to IDLE without TRAP_ACK.
- Edge n samples NICOND and the enable conditions.
  - n+1: TRAP_CYC=1, TRAP_ACK=1 (only this cycle), TRAP_ADDR valid, TRAP_COUNT updated.
- TRAP_DONE sampled at edge m: TRAP_CYC=0 from m+1 (DRAIN); IDLE from m+2.
  - The earliest next trap starts from a NICOND at edge m+2, with TRAP_CYC=1 at m+3.
- Hang: with no TRAP_DONE, TRAP_CYC lasts exactly TIMEOUT cycles; TRAP_HANG=1 in the following cycle.
- All outputs are registered except TRAP_PENDING.

## Test plan
- Overflow trap: TRAP_REQ1=1, TRAP_EN=1, PI_REQ=0, USER=1, NICOND pulse at edge 10.
  - Required: edge 11 TRAP_CYC=1, TRAP_ACK=1 for one cycle, TRAP_ADDR=9'o421, TRAP_UPT=1, TRAP_COUNT=1.
  - Then TRAP_DONE at edge 14: TRAP_CYC=0 at 15, IDLE at 16.
- Both requests with USER=0: TRAP_ADDR=9'o423, TRAP_UPT=0. Toggling USER and TRAP_REQ during CYCLE leaves TRAP_ADDR/TRAP_UPT unchanged.
- Deferral: TRAP_REQ2=1 with PI_REQ=1 at NICOND -> no TRAP_CYC, no TRAP_ACK, TRAP_PENDING stays 1.
  - Next NICOND with PI_REQ=0 -> trap with TRAP_ADDR=9'o422.
  - Repeat with TRAP_EN=0 -> no trap.
- Timeout with TIMEOUT=4 and no TRAP_DONE: TRAP_CYC high exactly 4 cycles, then TRAP_HANG=1 and IDLE.
  - HANG_CLR clears TRAP_HANG.
  - TRAP_DONE coincident with expiry -> TRAP_HANG stays 0.
- Reset mid-CYCLE (rst_n=0 one edge): all outputs at reset values the next cycle, TRAP_COUNT=0.
- Saturation with CNT_W=2: five back-to-back traps -> TRAP_COUNT ends at 3. NICOND pulses during CYCLE/DRAIN start no extra traps.

Source files
------------

// File: rtl/trap_seq.sv
// trap_seq: trap sequencer downstream of the SCD flag logic.
//
// At each instruction boundary (NICOND), this block samples the SCD arithmetic
// and pushdown trap requests and arbitrates them against pending priority
// interrupts. When a trap is taken, it runs a handshaked trap cycle with
// microcode: it presents the EPT/UPT trap offset, acknowledges the requests
// back to SCD, and flags a hung trap cycle. It also keeps a saturating count
// of the traps taken.
//
// Parameters
//   TIMEOUT      maximum cycles spent in a trap cycle before a hang (1..255)
//   CNT_W        width of the traps-taken counter
// Inputs
//   clk          system clock (rising edge)
//   rst_n        synchronous active-low reset
//   TRAP_REQ1    arithmetic overflow trap request
//   TRAP_REQ2    pushdown overflow trap request
//   USER         user mode; selects UPT (1) or EPT (0)
//   NICOND       one-cycle instruction-boundary strobe
//   PI_REQ       priority interrupt pending; outranks traps
//   TRAP_EN      trapping enabled
//   TRAP_DONE    microcode has finished with the trap instruction
//   HANG_CLR     clears TRAP_HANG
// Outputs
//   TRAP_PENDING combinational OR of the two requests
//   TRAP_CYC     trap cycle in progress
//   TRAP_ACK     one-cycle pulse telling SCD to clear its requests
//   TRAP_ADDR    trap offset 9'o420 + code; zero outside the trap cycle
//   TRAP_UPT     offset is UPT-relative; zero outside the trap cycle
//   TRAP_HANG    sticky timeout error
//   TRAP_COUNT   saturating count of trap cycles started
module trap_seq #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             TRAP_REQ1,
    input  logic             TRAP_REQ2,
    input  logic             USER,
    input  logic             NICOND,
    input  logic             PI_REQ,
    input  logic             TRAP_EN,
    input  logic             TRAP_DONE,
    input  logic             HANG_CLR,
    output logic             TRAP_PENDING,
    output logic             TRAP_CYC,
    output logic             TRAP_ACK,
    output logic [8:0]       TRAP_ADDR,
    output logic             TRAP_UPT,
    output logic             TRAP_HANG,
    output logic [CNT_W-1:0] TRAP_COUNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CYCLE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [1:0]       code_q, code_d;
    logic             user_q, user_d;
    logic             cyc_q, cyc_d;
    logic             ack_q, ack_d;
    logic [8:0]       addr_q, addr_d;
    logic             upt_q, upt_d;
    logic             hang_q, hang_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hang_set;
    logic [1:0]       req_code;

    assign req_code     = {TRAP_REQ2, TRAP_REQ1};
    assign TRAP_PENDING = TRAP_REQ1 | TRAP_REQ2;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        code_d   = code_q;
        user_d   = user_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        hang_set = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending PI or a disabled trap unit leaves the requests in
                // SCD untouched, so they are retried at a later boundary.
                if (NICOND && TRAP_EN && !PI_REQ && (req_code != 2'd0)) begin
                    state_d = CYCLE;
                    code_d  = req_code;
                    user_d  = USER;
                    tmo_d   = 8'd0;
                    ack_d   = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CYCLE: begin
                // TRAP_DONE is checked first so a completion on the expiry
                // cycle is not reported as a hang.
                if (TRAP_DONE) begin
                    state_d = DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = DRAIN;
                    hang_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            DRAIN: begin
                // This cycle lets the SCD-cleared requests settle before the
                // next boundary is sampled.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cyc_d  = (state_d == CYCLE);
        addr_d = cyc_d ? (9'o420 + {7'd0, code_d}) : 9'd0;
        upt_d  = cyc_d ? user_d : 1'b0;

        // A new hang outranks a simultaneous clear.
        if (hang_set) begin
            hang_d = 1'b1;
        end else if (HANG_CLR) begin
            hang_d = 1'b0;
        end else begin
            hang_d = hang_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmo_q   <= 8'd0;
            code_q  <= 2'd0;
            user_q  <= 1'b0;
            cyc_q   <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= 9'd0;
            upt_q   <= 1'b0;
            hang_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            user_q  <= user_d;
            cyc_q   <= cyc_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            upt_q   <= upt_d;
            hang_q  <= hang_d;
            cnt_q   <= cnt_d;
        end
    end

    assign TRAP_CYC   = cyc_q;
    assign TRAP_ACK   = ack_q;
    assign TRAP_ADDR  = addr_q;
    assign TRAP_UPT   = upt_q;
    assign TRAP_HANG  = hang_q;
    assign TRAP_COUNT = cnt_q;

endmodule

// File: tb/tb_trap_seq.sv
// Testbench for trap_seq: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model of the trap sequencer.
module tb_trap_seq;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             trap_req1 = 1'b0, trap_req2 = 1'b0, user = 1'b0;
    logic             nicond = 1'b0, pi_req = 1'b0, trap_en = 1'b0;
    logic             trap_done = 1'b0, hang_clr = 1'b0;
    logic             trap_pending, trap_cyc, trap_ack, trap_upt, trap_hang;
    logic [8:0]       trap_addr;
    logic [CNT_W-1:0] trap_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    trap_seq #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .TRAP_REQ1   (trap_req1),
        .TRAP_REQ2   (trap_req2),
        .USER        (user),
        .NICOND      (nicond),
        .PI_REQ      (pi_req),
        .TRAP_EN     (trap_en),
        .TRAP_DONE   (trap_done),
        .HANG_CLR    (hang_clr),
        .TRAP_PENDING(trap_pending),
        .TRAP_CYC    (trap_cyc),
        .TRAP_ACK    (trap_ack),
        .TRAP_ADDR   (trap_addr),
        .TRAP_UPT    (trap_upt),
        .TRAP_HANG   (trap_hang),
        .TRAP_COUNT  (trap_count)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Reference model: a trap in flight is described by how many cycles it
    // has already spent presenting its offset; a one-cycle settle gap follows.
    bit       m_in_trap, m_settle, m_ack, m_user, m_hang;
    int       m_age, m_count;
    bit [1:0] m_code;

    task automatic model_step();
        bit new_hang;
        new_hang = 1'b0;
        if (!rst_n) begin
            m_in_trap = 0; m_settle = 0; m_ack = 0; m_user = 0;
            m_hang = 0; m_age = 0; m_count = 0; m_code = 0;
            return;
        end
        m_ack = 0;
        if (m_in_trap) begin
            if (trap_done) begin
                m_in_trap = 0; m_settle = 1;
            end else if (m_age + 1 == TIMEOUT) begin
                m_in_trap = 0; m_settle = 1; new_hang = 1;
            end else begin
                m_age++;
            end
        end else if (m_settle) begin
            m_settle = 0;
        end else if (nicond && trap_en && !pi_req && (trap_req1 || trap_req2)) begin
            m_in_trap = 1;
            m_age     = 0;
            m_code    = {trap_req2, trap_req1};
            m_user    = user;
            m_ack     = 1;
            m_count   = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
        end
        if (new_hang) m_hang = 1;
        else if (hang_clr) m_hang = 0;
    endtask

    task automatic compare_all();
        check_eq("pending", int'(trap_pending), int'(trap_req1 | trap_req2));
        check_eq("cyc",     int'(trap_cyc),     int'(m_in_trap));
        check_eq("ack",     int'(trap_ack),     int'(m_ack));
        check_eq("addr",    int'(trap_addr),    m_in_trap ? ('o420 + int'(m_code)) : 0);
        check_eq("upt",     int'(trap_upt),     m_in_trap ? int'(m_user) : 0);
        check_eq("hang",    int'(trap_hang),    int'(m_hang));
        check_eq("count",   int'(trap_count),   m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    int cyc_len, acks;

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check_eq("rst_cyc", int'(trap_cyc), 0);
        check_eq("rst_count", int'(trap_count), 0);
        check_eq("rst_hang", int'(trap_hang), 0);
        rst_n = 1'b1;

        // Overflow trap in user mode
        trap_req1 = 1; trap_en = 1; user = 1;
        tick(); tick();
        nicond = 1;
        tick();
        check_eq("ovf_cyc", int'(trap_cyc), 1);
        check_eq("ovf_ack", int'(trap_ack), 1);
        check_eq("ovf_addr", int'(trap_addr), 'o421);
        check_eq("ovf_upt", int'(trap_upt), 1);
        check_eq("ovf_count", int'(trap_count), 1);
        nicond = 0; trap_req1 = 0; trap_done = 1;
        tick();
        check_eq("ovf_ack_drop", int'(trap_ack), 0);
        check_eq("ovf_drain_cyc", int'(trap_cyc), 0);
        trap_done = 0;
        tick();

        // Both requests, executive mode; inputs toggled mid-cycle
        trap_req1 = 1; trap_req2 = 1; user = 0; nicond = 1;
        tick();
        check_eq("both_addr", int'(trap_addr), 'o423);
        check_eq("both_upt", int'(trap_upt), 0);
        nicond = 0; user = 1; trap_req1 = 0;
        tick();
        check_eq("both_addr_hold", int'(trap_addr), 'o423);
        check_eq("both_upt_hold", int'(trap_upt), 0);
        trap_done = 1; tick(); trap_done = 0; tick();

        // Deferral by PI, then take, then disabled
        trap_req1 = 0; trap_req2 = 1; user = 0; pi_req = 1; nicond = 1;
        tick();
        check_eq("defer_cyc", int'(trap_cyc), 0);
        check_eq("defer_ack", int'(trap_ack), 0);
        check_eq("defer_pending", int'(trap_pending), 1);
        nicond = 0; pi_req = 0; tick();
        nicond = 1; tick();
        check_eq("defer_addr", int'(trap_addr), 'o422);
        nicond = 0; trap_done = 1; tick(); trap_done = 0; tick();
        trap_en = 0; nicond = 1; tick();
        check_eq("dis_cyc", int'(trap_cyc), 0);
        nicond = 0; trap_en = 1; tick();

        // Timeout without TRAP_DONE
        trap_req2 = 0; trap_req1 = 1; nicond = 1;
        tick();
        nicond = 0;
        cyc_len = 0;
        for (int i = 0; i < 20 && trap_cyc; i++) begin
            cyc_len++;
            tick();
        end
        check_eq("tmo_len", cyc_len, TIMEOUT);
        check_eq("tmo_hang", int'(trap_hang), 1);
        tick();
        hang_clr = 1; tick(); hang_clr = 0;
        check_eq("hang_clr", int'(trap_hang), 0);

        // TRAP_DONE on the expiry cycle
        nicond = 1; tick(); nicond = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        trap_done = 1; tick(); trap_done = 0;
        check_eq("done_wins_hang", int'(trap_hang), 0);
        check_eq("done_wins_cyc", int'(trap_cyc), 0);
        tick();

        // Reset mid-cycle
        nicond = 1; tick(); nicond = 0; tick();
        rst_n = 0; tick(); rst_n = 1;
        check_eq("rstmid_cyc", int'(trap_cyc), 0);
        check_eq("rstmid_ack", int'(trap_ack), 0);
        check_eq("rstmid_addr", int'(trap_addr), 0);
        check_eq("rstmid_count", int'(trap_count), 0);

        // Back-to-back traps with NICOND held high: one trap per three edges
        nicond = 1; trap_done = 1; acks = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (trap_ack) acks++;
        end
        nicond = 0; trap_done = 0;
        check_eq("sat_acks", acks, 5);
        check_eq("sat_count", int'(trap_count), CNT_MAX);
        tick(); tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            trap_req1 = ($urandom_range(0, 2) == 0);
            trap_req2 = ($urandom_range(0, 2) == 0);
            user      = $urandom_range(0, 1);
            nicond    = ($urandom_range(0, 2) == 0);
            pi_req    = ($urandom_range(0, 3) == 0);
            trap_en   = ($urandom_range(0, 9) != 0);
            trap_done = ($urandom_range(0, 4) == 0);
            hang_clr  = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
